// File: rtl/core_pkg.sv
// Shared core types for the LETC stage-2 slice.
// Word, comparator op and branch controller state.
package core_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    typedef enum logic [2:0] {
        CMP_EQ  = 3'd0,
        CMP_NE  = 3'd1,
        CMP_LT  = 3'd2,
        CMP_GE  = 3'd3,
        CMP_LTU = 3'd4,
        CMP_GEU = 3'd5
    } cmp_op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } branch_state_e;

endpackage

// File: rtl/core_s2_branch_target.sv
// Stage-2 control-transfer target computation.
// Priority select jalr > jal > branch, plus alignment check.
module core_s2_branch_target
    import core_pkg::*;
(
    input  logic  is_branch,
    input  logic  is_jal,
    input  logic  is_jalr,
    input  logic  cmp_result,
    input  word_t pc,
    input  word_t imm,
    input  word_t rs1,
    output logic  taken,
    output word_t target,
    output logic  misaligned
);

    word_t pc_sum;
    word_t rs1_sum;

    // Resolve taken/target; a taken target with bit 1 set is a fault.
    always_comb begin
        pc_sum     = pc + imm;
        rs1_sum    = rs1 + imm;
        taken      = 1'b0;
        target     = pc_sum;
        if (is_jalr) begin
            taken  = 1'b1;
            target = {rs1_sum[XLEN-1:1], 1'b0};
        end else if (is_jal) begin
            taken  = 1'b1;
        end else if (is_branch) begin
            taken  = cmp_result;
        end
        misaligned = taken & target[1];
    end

endmodule

// File: rtl/core_s2_branch_ctrl.sv
// Stage-2 branch resolution controller.
// Redirects fetch on taken transfers and squashes younger slots.
module core_s2_branch_ctrl
    import core_pkg::*;
#(
    parameter int FLUSH_DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    s2_valid,
    output logic    s2_ready,
    input  logic    s2_is_branch,
    input  logic    s2_is_jal,
    input  logic    s2_is_jalr,
    input  cmp_op_e s2_cmp_op,
    input  word_t   s2_pc,
    input  word_t   s2_imm,
    input  word_t   rs1_ff,
    output cmp_op_e cmp_operation,
    input  logic    cmp_result,
    output logic    redirect_valid,
    input  logic    redirect_ready,
    output word_t   redirect_pc,
    output logic    flush_younger,
    output logic    misaligned_fault
);

    localparam int CW =
        (FLUSH_DEPTH < 1) ? 1 : $clog2(FLUSH_DEPTH + 1);
    localparam int LOAD_I =
        (FLUSH_DEPTH > 0) ? FLUSH_DEPTH - 1 : 0;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LOAD_I);

    branch_state_e state_q;
    branch_state_e state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    logic  taken;
    logic  misaligned;
    word_t target;
    logic  accept;
    logic  load_redirect;
    logic  fault_d;

    assign cmp_operation = s2_cmp_op;
    assign s2_ready      = (state_q == IDLE);
    assign accept        = s2_ready & s2_valid;
    assign load_redirect = accept & taken & ~misaligned;
    assign fault_d       = accept & taken & misaligned;

    core_s2_branch_target u_target (
        .is_branch  (s2_is_branch),
        .is_jal     (s2_is_jal),
        .is_jalr    (s2_is_jalr),
        .cmp_result (cmp_result),
        .pc         (s2_pc),
        .imm        (s2_imm),
        .rs1        (rs1_ff),
        .taken      (taken),
        .target     (target),
        .misaligned (misaligned)
    );

    // Next-state and squash counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (load_redirect) begin
                    state_d = REDIRECT;
                end
            end
            REDIRECT: begin
                if (redirect_ready) begin
                    if (FLUSH_DEPTH == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = FLUSH;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            redirect_valid   <= 1'b0;
            redirect_pc      <= '0;
            flush_younger    <= 1'b0;
            misaligned_fault <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            redirect_valid   <= (state_d == REDIRECT);
            flush_younger    <= (state_d != IDLE);
            misaligned_fault <= fault_d;
            if (load_redirect) begin
                redirect_pc <= target;
            end
        end
    end

endmodule

// File: tb/tb_core_s2_branch_ctrl.sv
// Bench for core_s2_branch_ctrl: default and zero-depth builds.
// Reference model plus directed literal expectations.
module tb_core_s2_branch_ctrl;
    import core_pkg::*;

    logic    clk = 1'b0;
    logic    rst_n = 1'b0;
    logic    s2_valid;
    logic    s2_is_branch;
    logic    s2_is_jal;
    logic    s2_is_jalr;
    cmp_op_e s2_cmp_op;
    word_t   s2_pc;
    word_t   s2_imm;
    word_t   rs1_ff;
    logic    cmp_result;
    logic    redirect_ready;
    logic    run = 1'b0;

    logic    rdy   [2];
    logic    rv    [2];
    logic    fy    [2];
    logic    fault [2];
    word_t   rpc   [2];
    cmp_op_e cop   [2];

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    core_s2_branch_ctrl #(.FLUSH_DEPTH(2)) dut0 (
        .clk (clk), .rst_n (rst_n),
        .s2_valid (s2_valid), .s2_ready (rdy[0]),
        .s2_is_branch (s2_is_branch), .s2_is_jal (s2_is_jal),
        .s2_is_jalr (s2_is_jalr), .s2_cmp_op (s2_cmp_op),
        .s2_pc (s2_pc), .s2_imm (s2_imm), .rs1_ff (rs1_ff),
        .cmp_operation (cop[0]), .cmp_result (cmp_result),
        .redirect_valid (rv[0]), .redirect_ready (redirect_ready),
        .redirect_pc (rpc[0]), .flush_younger (fy[0]),
        .misaligned_fault (fault[0])
    );

    core_s2_branch_ctrl #(.FLUSH_DEPTH(0)) dut1 (
        .clk (clk), .rst_n (rst_n),
        .s2_valid (s2_valid), .s2_ready (rdy[1]),
        .s2_is_branch (s2_is_branch), .s2_is_jal (s2_is_jal),
        .s2_is_jalr (s2_is_jalr), .s2_cmp_op (s2_cmp_op),
        .s2_pc (s2_pc), .s2_imm (s2_imm), .rs1_ff (rs1_ff),
        .cmp_operation (cop[1]), .cmp_result (cmp_result),
        .redirect_valid (rv[1]), .redirect_ready (redirect_ready),
        .redirect_pc (rpc[1]), .flush_younger (fy[1]),
        .misaligned_fault (fault[1])
    );

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: pending redirect, squash cycles left, last target.
    logic  m_pend  [2];
    int    m_left  [2];
    word_t m_tgt   [2];
    logic  m_fault [2];

    function automatic logic m_taken();
        return s2_is_jalr || s2_is_jal || (s2_is_branch && cmp_result);
    endfunction

    function automatic word_t m_target();
        if (s2_is_jalr) return ((rs1_ff + s2_imm) / 2) * 2;
        return s2_pc + s2_imm;
    endfunction

    function automatic logic m_misal();
        return (m_target() % 4) >= 2;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_pend[i]  <= 1'b0;
                m_left[i]  <= 0;
                m_tgt[i]   <= '0;
                m_fault[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_fault[i] <= 1'b0;
                if (m_pend[i]) begin
                    if (redirect_ready) begin
                        m_pend[i] <= 1'b0;
                        m_left[i] <= (i == 0) ? 2 : 0;
                    end
                end else if (m_left[i] > 0) begin
                    m_left[i] <= m_left[i] - 1;
                end else if (s2_valid && m_taken()) begin
                    if (m_misal()) begin
                        m_fault[i] <= 1'b1;
                    end else begin
                        m_pend[i] <= 1'b1;
                        m_tgt[i]  <= m_target();
                    end
                end
            end
        end
    end

    // Every-cycle comparison of both builds against the model.
    always @(negedge clk) begin
        if (rst_n && run) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("m_rv%0d", i), 32'(rv[i]), 32'(m_pend[i]));
                chk($sformatf("m_pc%0d", i), rpc[i], m_tgt[i]);
                chk($sformatf("m_fy%0d", i), 32'(fy[i]),
                    32'(m_pend[i] || m_left[i] > 0));
                chk($sformatf("m_rdy%0d", i), 32'(rdy[i]),
                    32'(!(m_pend[i] || m_left[i] > 0)));
                chk($sformatf("m_flt%0d", i), 32'(fault[i]),
                    32'(m_fault[i]));
                chk($sformatf("m_op%0d", i), 32'(cop[i]),
                    32'(s2_cmp_op));
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic idle_in();
        s2_valid     = 1'b0;
        s2_is_branch = 1'b0;
        s2_is_jal    = 1'b0;
        s2_is_jalr   = 1'b0;
        cmp_result   = 1'b0;
    endtask

    task automatic drive(input logic br, input logic jal,
                         input logic jalr, input cmp_op_e op,
                         input word_t pc, input word_t imm,
                         input word_t rs1, input logic cr);
        s2_valid     = 1'b1;
        s2_is_branch = br;
        s2_is_jal    = jal;
        s2_is_jalr   = jalr;
        s2_cmp_op    = op;
        s2_pc        = pc;
        s2_imm       = imm;
        rs1_ff       = rs1;
        cmp_result   = cr;
    endtask

    int lowc0;
    int lowc1;
    int fyc1;

    initial begin
        idle_in();
        redirect_ready = 1'b0;
        s2_cmp_op      = CMP_EQ;
        s2_pc          = '0;
        s2_imm         = '0;
        rs1_ff         = '0;
        #1;
        chk("rst_ready", 32'(rdy[0]), 32'd1);
        chk("rst_rv", 32'(rv[0]), 32'd0);
        chk("rst_pc", rpc[0], 32'h0);
        chk("rst_fy", 32'(fy[0]), 32'd0);
        chk("rst_fault", 32'(fault[0]), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        run   = 1'b1;

        // BEQ taken, immediate handshake
        redirect_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b0, CMP_EQ, 32'h100, 32'h20, 32'h0, 1'b1);
        #1;
        chk("cmp_op_eq", 32'(cop[0]), 32'(CMP_EQ));
        step();
        idle_in();
        chk("beq_rv", 32'(rv[0]), 32'd1);
        chk("beq_pc", rpc[0], 32'h120);
        chk("beq_rdy", 32'(rdy[0]), 32'd0);
        lowc0 = 0;
        lowc1 = 0;
        fyc1  = 0;
        for (int k = 0; k < 8; k++) begin
            if (!rdy[0]) lowc0++;
            if (!rdy[1]) lowc1++;
            if (fy[1]) fyc1++;
            step();
        end
        chk("beq_stall", 32'(lowc0), 32'd3);
        chk("d0_stall", 32'(lowc1), 32'd1);
        chk("d0_flush", 32'(fyc1), 32'd1);

        // BNE not taken
        drive(1'b1, 1'b0, 1'b0, CMP_NE, 32'h200, 32'h40, 32'h0, 1'b0);
        step();
        idle_in();
        chk("bne_rv", 32'(rv[0]), 32'd0);
        chk("bne_fy", 32'(fy[0]), 32'd0);
        chk("bne_rdy", 32'(rdy[0]), 32'd1);

        // JALR with target bit 1 set
        drive(1'b0, 1'b0, 1'b1, CMP_EQ, 32'h0, 32'h0, 32'h1003, 1'b0);
        step();
        idle_in();
        chk("jalr_flt", 32'(fault[0]), 32'd1);
        chk("jalr_flt_rv", 32'(rv[0]), 32'd0);
        step();
        chk("jalr_flt_end", 32'(fault[0]), 32'd0);
        chk("jalr_flt_rdy", 32'(rdy[0]), 32'd1);

        // JALR aligned, bit 0 cleared
        drive(1'b0, 1'b0, 1'b1, CMP_EQ, 32'h0, 32'h0, 32'h1001, 1'b0);
        step();
        idle_in();
        chk("jalr_pc", rpc[0], 32'h1000);
        chk("jalr_rv", 32'(rv[0]), 32'd1);
        repeat (4) step();

        // JAL wrapping target under backpressure
        redirect_ready = 1'b0;
        drive(1'b0, 1'b1, 1'b0, CMP_EQ, 32'hFFFF_FFF0, 32'h20,
              32'h0, 1'b0);
        step();
        idle_in();
        for (int k = 0; k < 4; k++) begin
            chk("jal_rv", 32'(rv[0]), 32'd1);
            chk("jal_pc", rpc[0], 32'h10);
            chk("jal_rdy", 32'(rdy[0]), 32'd0);
            step();
        end
        redirect_ready = 1'b1;
        repeat (4) step();

        // BLTU taken on the zero-depth build
        drive(1'b1, 1'b0, 1'b0, CMP_LTU, 32'h300, 32'h40, 32'h0, 1'b1);
        step();
        idle_in();
        chk("bltu_rv", 32'(rv[1]), 32'd1);
        chk("bltu_pc", rpc[1], 32'h340);
        chk("bltu_fy", 32'(fy[1]), 32'd1);
        step();
        chk("bltu_fy_end", 32'(fy[1]), 32'd0);
        chk("bltu_rdy", 32'(rdy[1]), 32'd1);
        repeat (3) step();

        // Back-to-back taken JALs with toggling handshake
        for (int k = 0; k < 14; k++) begin
            redirect_ready = k[0];
            drive(1'b0, 1'b1, 1'b0, CMP_GE, 32'h400 + 32'(k * 16),
                  32'h8, 32'h0, 1'b0);
            step();
        end
        idle_in();
        redirect_ready = 1'b1;
        repeat (4) step();

        // Asynchronous reset in the middle of REDIRECT
        redirect_ready = 1'b0;
        drive(1'b0, 1'b1, 1'b0, CMP_EQ, 32'h500, 32'h10, 32'h0, 1'b0);
        step();
        idle_in();
        chk("pre_rst_rv", 32'(rv[0]), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_rv", 32'(rv[0]), 32'd0);
        chk("arst_fy", 32'(fy[0]), 32'd0);
        chk("arst_rdy", 32'(rdy[0]), 32'd1);
        chk("arst_pc", rpc[0], 32'h0);
        step();
        rst_n = 1'b1;
        redirect_ready = 1'b1;
        step();
        chk("post_rst_rdy", 32'(rdy[0]), 32'd1);
        chk("post_rst_rv", 32'(rv[0]), 32'd0);
        step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/core_s2_branch_ctrl.md
# core_s2_branch_ctrl

Stage-2 branch resolution controller for the LETC core. It drives the operation select of the stage-2 comparator and decides taken/not-taken for BEQ/BNE/BLT/BGE/BLTU/BGEU. It computes targets for branches, JAL and JALR, issues a registered redirect to fetch over a valid/ready handshake, and squashes younger in-flight instructions. Fetch predicts not-taken; this block corrects every taken control transfer.

## Interface
Parameters:
- FLUSH_DEPTH, default 2: cycles of post-redirect squash that cover younger slots still in flight; legal range 0..7.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous, active-low
- s2_valid  in  1  instruction present in stage 2
- s2_ready  out  1  stage 2 may retire its instruction this cycle
- s2_is_branch  in  1  conditional branch
- s2_is_jal  in  1  JAL
- s2_is_jalr  in  1  JALR
- s2_cmp_op  in  cmp_op_e  decoded comparison for the branch
- s2_pc  in  word_t  PC of stage-2 instruction
- s2_imm  in  word_t  sign-extended immediate
- rs1_ff  in  word_t  forwarded rs1, used as the JALR base
- cmp_operation  out  cmp_op_e  to comparator; combinational copy of s2_cmp_op
- cmp_result  in  1  comparator result
- redirect_valid  out  1  redirect request to fetch
- redirect_ready  in  1  fetch accepts redirect
- redirect_pc  out  word_t  redirect target; stable while redirect_valid=1
- flush_younger  out  1  squash all instructions younger than the resolved one
- misaligned_fault  out  1  one-cycle pulse: taken target not 4-byte aligned

## Operation
- States: IDLE, REDIRECT, FLUSH (branch_state_e).
- Accept cycle: s2_valid=1 in IDLE. The instruction retires because s2_ready=1 in IDLE.
- Taken condition: s2_is_jalr, or s2_is_jal, or (s2_is_branch and cmp_result). The flags are one-hot; if several are set, priority is jalr > jal > branch.
- Target for branch/JAL: s2_pc + s2_imm, modulo 2^32.
- Target for JALR: (rs1_ff + s2_imm) with bit 0 forced to 0.
- Taken and target[1]=1: no redirect and no state change. misaligned_fault pulses on the next cycle.
- Taken and target[1]=0: latch the target into redirect_pc and go to REDIRECT.
- Not taken, or non-control instruction: stay in IDLE with no outputs asserted.
- REDIRECT:
  - redirect_valid=1, s2_ready=0, flush_younger=1.
  - On redirect_ready=1, go to FLUSH with the counter loaded to FLUSH_DEPTH-1. If FLUSH_DEPTH=0, go straight to IDLE.
- FLUSH:
  - s2_ready=0, flush_younger=1, counter decrements each cycle.
  - Go to IDLE in the cycle the counter is 0.
- s2 inputs are ignored outside IDLE.
- Counter width is $clog2(FLUSH_DEPTH+1), with a minimum of 1.

## Timing
- Reset values: state IDLE, counter 0, redirect_valid 0, redirect_pc 0, flush_younger 0, misaligned_fault 0. s2_ready reads 1 in reset because it is decoded from IDLE.
- Reset asserted mid-REDIRECT or mid-FLUSH drops every output to its reset value immediately, without waiting for a clock edge.
- Decision is combinational in accept cycle N. redirect_valid, redirect_pc and misaligned_fault are registered and first visible at N+1.
- flush_younger is registered and asserted from N+1 through the final FLUSH cycle.
- redirect_valid must never drop before the handshake. redirect_ready may already be high at N+1, giving a single-cycle REDIRECT.
- Total stall for a taken transfer: 1 (REDIRECT, minimum) + FLUSH_DEPTH cycles of s2_ready=0.
- Back-to-back: a control instruction arriving in the cycle FLUSH exits is accepted normally in IDLE on the following cycle.

## Structure
- core_pkg: add branch_state_e (IDLE/REDIRECT/FLUSH). cmp_op_e and word_t are reused from core_pkg/letc_pkg.
- One natural sub-module: core_s2_branch_target. It is combinational and contains the target adder, the JALR bit-0 clear, the misalignment check and the priority select.
- The comparator stays outside; the top-level stage-2 module wires cmp_operation/cmp_result between the two.

## Test plan
- BEQ, rs1=rs2 (cmp_result=1), pc=0x100, imm=0x20: redirect_valid=1, redirect_pc=0x120 at N+1. With redirect_ready=1, then 2 FLUSH cycles, then IDLE; s2_ready low for 3 cycles total.
- BNE not taken (cmp_result=0), pc=0x200: no redirect, flush_younger=0, s2_ready stays 1.
- JALR rs1_ff=0x1003, imm=0: redirect_pc=0x1002 → bit1 set → misaligned_fault pulses 1 cycle, no redirect. Repeat with rs1_ff=0x1001: redirect_pc=0x1000.
- JAL pc=0xFFFFFFF0, imm=0x20: redirect_pc=0x00000010 (wrap). Hold redirect_ready=0 for 4 cycles: redirect_valid and redirect_pc stay stable, s2_ready=0 throughout.
- Assert rst_n=0 in the middle of REDIRECT: redirect_valid and flush_younger drop without a clock edge. After release the block is in IDLE and s2_ready=1.
- FLUSH_DEPTH=0 build, taken BLTU: IDLE→REDIRECT→IDLE. flush_younger asserted exactly for the handshake cycle.
